// File: rtl/regfile_port_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : regfile_port_ctrl_pkg
// Purpose : Shared types and constants for the register-file port controller:
//           the sequencer state encoding, the default geometry of the integer
//           register file and the index of the hard-wired zero register.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package regfile_port_ctrl_pkg;

    // Default geometry of the architectural register file.
    localparam int NREGS_DEFAULT = 32;
    localparam int XLEN_DEFAULT  = 32;

    // x0 always reads as zero; the controller never lets a non-zero value
    // reach it through the write port.
    localparam logic [4:0] X0_IDX = 5'd0;

    // Sequencer states.
    //   ST_CLEAR    : post-reset walk writing zero to every register
    //   ST_RUN      : normal operation, writeback owns the write port
    //   ST_DBG_READ : debug read has borrowed read port 1, decode stalled
    //   ST_DBG_ACK  : debug completion cycle
    typedef enum logic [1:0] {
        ST_CLEAR    = 2'd0,
        ST_RUN      = 2'd1,
        ST_DBG_READ = 2'd2,
        ST_DBG_ACK  = 2'd3
    } state_e;

endpackage : regfile_port_ctrl_pkg
`default_nettype wire

// File: rtl/regfile_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : regfile_port_ctrl
// Purpose : Sequencer/arbiter for the integer register file's write port and
//           read port 1. After reset it writes zero to every register, then
//           gives the write port to pipeline writeback and slots debug
//           reads/writes into the gaps. The register file writes every clock,
//           so an idle write port is driven as the harmless write x0 <- 0.
//
// Configuration:
//   REGFILE_DEBUG_PORT_EN  defined   : debug requester is serviced
//                          undefined : dbg_* inputs ignored, dbg_ack/dbg_rdata
//                                      tied to zero, stall only during clear
//
// Ports:
//   clk, rst_n          clock (rising edge), synchronous active-low reset
//   wb_valid/_rd_*      writeback request (address, data)
//   dec_rs1_address     decode's read-port-1 address
//   rf_rs1_address/data register file read port 1
//   rf_rd_address/data  register file write port (written every cycle)
//   stall               freeze decode and upstream
//   init_done           clear sequence finished (registered)
//   dbg_req/we/addr/    debug request, held until dbg_ack
//   dbg_wdata
//   dbg_ack             one-cycle completion pulse (registered)
//   dbg_rdata           read result, valid with dbg_ack, held until next ack
// Revision: 1.0 - initial release
// ============================================================================
module regfile_port_ctrl
    import regfile_port_ctrl_pkg::*;
#(
    parameter int NREGS = NREGS_DEFAULT,
    parameter int XLEN  = XLEN_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wb_valid,
    input  logic [$clog2(NREGS)-1:0] wb_rd_address,
    input  logic [XLEN-1:0]          wb_rd_data,
    input  logic [$clog2(NREGS)-1:0] dec_rs1_address,
    output logic [$clog2(NREGS)-1:0] rf_rs1_address,
    input  logic [XLEN-1:0]          rf_rs1_data,
    output logic [$clog2(NREGS)-1:0] rf_rd_address,
    output logic [XLEN-1:0]          rf_rd_data,
    output logic                     stall,
    output logic                     init_done,
    input  logic                     dbg_req,
    input  logic                     dbg_we,
    input  logic [$clog2(NREGS)-1:0] dbg_addr,
    input  logic [XLEN-1:0]          dbg_wdata,
    output logic                     dbg_ack,
    output logic [XLEN-1:0]          dbg_rdata
);

    localparam int            AW       = $clog2(NREGS);
    localparam logic [AW-1:0] ZERO_IDX = AW'(X0_IDX);
    localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

    state_e          state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic            init_done_q, init_done_d;
    logic [AW-1:0]   wr_addr;
    logic [XLEN-1:0] wr_data;

`ifdef REGFILE_DEBUG_PORT_EN
    logic            dbg_ack_q, dbg_ack_d;
    logic [XLEN-1:0] dbg_rdata_q, dbg_rdata_d;
`endif

    // ------------------------------------------------------------------
    // State and counter registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_CLEAR;
            cnt_q       <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_done_q <= init_done_d;
        end
    end

`ifdef REGFILE_DEBUG_PORT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dbg_ack_q   <= 1'b0;
            dbg_rdata_q <= '0;
        end else begin
            dbg_ack_q   <= dbg_ack_d;
            dbg_rdata_q <= dbg_rdata_d;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Next-state and port muxes
    // ------------------------------------------------------------------
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        init_done_d    = init_done_q;
        wr_addr        = ZERO_IDX;
        wr_data        = '0;
        rf_rs1_address = dec_rs1_address;
        stall          = 1'b0;
`ifdef REGFILE_DEBUG_PORT_EN
        dbg_rdata_d    = dbg_rdata_q;
`endif

        case (state_q)
            ST_CLEAR: begin
                wr_addr = cnt_q;
                stall   = 1'b1;
                cnt_d   = cnt_q + AW'(1);
                if (cnt_q == LAST_IDX) begin
                    state_d     = ST_RUN;
                    init_done_d = 1'b1;
                end
            end

            ST_RUN: begin
                if (wb_valid) begin
                    wr_addr = wb_rd_address;
                    wr_data = wb_rd_data;
                end
`ifdef REGFILE_DEBUG_PORT_EN
                // A debug write only gets the port when writeback is idle;
                // otherwise it simply waits here and retries next cycle.
                else if (dbg_req && dbg_we) begin
                    wr_addr = dbg_addr;
                    wr_data = dbg_wdata;
                    state_d = ST_DBG_ACK;
                end
                // Reads use read port 1, so they never contend with writeback.
                if (dbg_req && !dbg_we) begin
                    state_d = ST_DBG_READ;
                end
`endif
            end

`ifdef REGFILE_DEBUG_PORT_EN
            ST_DBG_READ: begin
                if (wb_valid) begin
                    wr_addr = wb_rd_address;
                    wr_data = wb_rd_data;
                end
                rf_rs1_address = dbg_addr;
                stall          = 1'b1;
                // The register file only shows this cycle's writeback next
                // cycle, so forward it to keep the debug read coherent.
                if (dbg_addr == ZERO_IDX) begin
                    dbg_rdata_d = '0;
                end else if (wb_valid && (wb_rd_address == dbg_addr)) begin
                    dbg_rdata_d = wb_rd_data;
                end else begin
                    dbg_rdata_d = rf_rs1_data;
                end
                state_d = ST_DBG_ACK;
            end

            ST_DBG_ACK: begin
                if (wb_valid) begin
                    wr_addr = wb_rd_address;
                    wr_data = wb_rd_data;
                end
                state_d = ST_RUN;
            end
`endif

            default: begin
                state_d = ST_CLEAR;
            end
        endcase

`ifdef REGFILE_DEBUG_PORT_EN
        dbg_ack_d = (state_d == ST_DBG_ACK);
`endif
    end

    // x0 is hard-wired to zero: whatever source targets it, write zero.
    assign rf_rd_address = wr_addr;
    assign rf_rd_data    = (wr_addr == ZERO_IDX) ? '0 : wr_data;
    assign init_done     = init_done_q;

`ifdef REGFILE_DEBUG_PORT_EN
    assign dbg_ack   = dbg_ack_q;
    assign dbg_rdata = dbg_rdata_q;
`else
    logic unused_dbg;
    assign unused_dbg = ^{dbg_req, dbg_we, dbg_addr, dbg_wdata, rf_rs1_data};
    assign dbg_ack    = 1'b0;
    assign dbg_rdata  = '0;
`endif

endmodule : regfile_port_ctrl
`default_nettype wire

// File: tb/tb_regfile_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_regfile_port_ctrl
// Purpose : Directed self-checking bench for regfile_port_ctrl. A small
//           behavioural register file closes the loop around the DUT.
//           Inputs change on the falling edge; outputs are sampled 1 ns later.
// Revision: 1.0 - initial release
// ============================================================================
module tb_regfile_port_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wb_valid;
    logic [4:0]  wb_rd_address;
    logic [31:0] wb_rd_data;
    logic [4:0]  dec_rs1_address;
    logic [4:0]  rf_rs1_address;
    logic [31:0] rf_rs1_data;
    logic [4:0]  rf_rd_address;
    logic [31:0] rf_rd_data;
    logic        stall;
    logic        init_done;
    logic        dbg_req;
    logic        dbg_we;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_wdata;
    logic        dbg_ack;
    logic [31:0] dbg_rdata;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    regfile_port_ctrl dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .wb_valid        (wb_valid),
        .wb_rd_address   (wb_rd_address),
        .wb_rd_data      (wb_rd_data),
        .dec_rs1_address (dec_rs1_address),
        .rf_rs1_address  (rf_rs1_address),
        .rf_rs1_data     (rf_rs1_data),
        .rf_rd_address   (rf_rd_address),
        .rf_rd_data      (rf_rd_data),
        .stall           (stall),
        .init_done       (init_done),
        .dbg_req         (dbg_req),
        .dbg_we          (dbg_we),
        .dbg_addr        (dbg_addr),
        .dbg_wdata       (dbg_wdata),
        .dbg_ack         (dbg_ack),
        .dbg_rdata       (dbg_rdata)
    );

    // Behavioural register file: writes every clock, combinational read.
    logic [31:0] mem [32];
    always @(posedge clk) mem[rf_rd_address] <= rf_rd_data;
    assign rf_rs1_data = mem[rf_rs1_address];

    // Move to the next falling edge, then let combinational outputs settle.
    task automatic next_cyc();
        @(negedge clk);
    endtask

    task automatic reset_and_clear();
        bit done;
        rst_n = 1'b0;
        next_cyc();
        next_cyc();
        rst_n = 1'b1;
        done  = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            next_cyc();
            #1;
            if (init_done === 1'b1) done = 1'b1;
        end
        n_chk++;
        if (done !== 1'b1) $display("FAIL clear_timeout: init_done=%b required 1", init_done);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        next_cyc();
        next_cyc();
        #1;
        n_chk++; if (init_done !== 1'b0) $display("FAIL rst_init_done: got %b want 0", init_done); else n_pass++;
        n_chk++; if (dbg_ack !== 1'b0) $display("FAIL rst_dbg_ack: got %b want 0", dbg_ack); else n_pass++;
        n_chk++; if (dbg_rdata !== 32'h0) $display("FAIL rst_dbg_rdata: got %h want 0", dbg_rdata); else n_pass++;
        n_chk++; if (stall !== 1'b1) $display("FAIL rst_stall: got %b want 1", stall); else n_pass++;
    endtask

    task automatic test_clear_walk();
        next_cyc();
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            #1;
            n_chk++; if (rf_rd_address !== 5'(i)) $display("FAIL clr_addr[%0d]: got %0d want %0d", i, rf_rd_address, i); else n_pass++;
            n_chk++; if (rf_rd_data !== 32'h0 || stall !== 1'b1 || init_done !== 1'b0)
                $display("FAIL clr_ctl[%0d]: data=%h stall=%b init_done=%b want 0/1/0", i, rf_rd_data, stall, init_done);
            else n_pass++;
            next_cyc();
        end
        #1;
        n_chk++; if (init_done !== 1'b1) $display("FAIL clr_done: got %b want 1", init_done); else n_pass++;
        n_chk++; if (stall !== 1'b0) $display("FAIL clr_stall_off: got %b want 0", stall); else n_pass++;
    endtask

    task automatic test_clear_restart();
        rst_n = 1'b0;
        next_cyc();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) next_cyc();
        #1;
        n_chk++; if (rf_rd_address !== 5'd10) $display("FAIL restart_pre: got %0d want 10", rf_rd_address); else n_pass++;
        rst_n = 1'b0;
        next_cyc();
        rst_n = 1'b1;
        #1;
        n_chk++; if (rf_rd_address !== 5'd0 || stall !== 1'b1) $display("FAIL restart_addr0: addr=%0d stall=%b want 0/1", rf_rd_address, stall); else n_pass++;
        next_cyc();
        #1;
        n_chk++; if (rf_rd_address !== 5'd1) $display("FAIL restart_addr1: got %0d want 1", rf_rd_address); else n_pass++;
    endtask

    task automatic test_run_idle();
        for (int i = 0; i < 4; i++) begin
            next_cyc();
            #1;
            n_chk++; if (rf_rd_address !== 5'd0 || rf_rd_data !== 32'h0 || stall !== 1'b0)
                $display("FAIL idle[%0d]: addr=%0d data=%h stall=%b want 0/0/0", i, rf_rd_address, rf_rd_data, stall);
            else n_pass++;
        end
        next_cyc();
        wb_valid = 1'b1; wb_rd_address = 5'd0; wb_rd_data = 32'hDEADBEEF;
        #1;
        n_chk++; if (rf_rd_address !== 5'd0 || rf_rd_data !== 32'h0) $display("FAIL wb_x0: addr=%0d data=%h want 0/0", rf_rd_address, rf_rd_data); else n_pass++;
        next_cyc();
        wb_rd_address = 5'd12; wb_rd_data = 32'hCAFEF00D;
        #1;
        n_chk++; if (rf_rd_address !== 5'd12 || rf_rd_data !== 32'hCAFEF00D) $display("FAIL wb_x12: addr=%0d data=%h want 12/cafef00d", rf_rd_address, rf_rd_data); else n_pass++;
        next_cyc();
        wb_valid = 1'b0;
        #1;
        n_chk++; if (mem[12] !== 32'hCAFEF00D) $display("FAIL wb_x12_mem: got %h want cafef00d", mem[12]); else n_pass++;
    endtask

`ifdef REGFILE_DEBUG_PORT_EN
    task automatic test_dbg_write();
        next_cyc();
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd5; dbg_wdata = 32'h12345678;
        wb_valid = 1'b1; wb_rd_address = 5'd20; wb_rd_data = 32'h11111111;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_chk++; if (rf_rd_address !== 5'd20 || rf_rd_data !== 32'h11111111 || dbg_ack !== 1'b0)
                $display("FAIL dbgw_blocked[%0d]: addr=%0d data=%h ack=%b want 20/11111111/0", i, rf_rd_address, rf_rd_data, dbg_ack);
            else n_pass++;
            next_cyc();
        end
        wb_valid = 1'b0;
        #1;
        n_chk++; if (rf_rd_address !== 5'd5 || rf_rd_data !== 32'h12345678 || dbg_ack !== 1'b0)
            $display("FAIL dbgw_write: addr=%0d data=%h ack=%b want 5/12345678/0", rf_rd_address, rf_rd_data, dbg_ack);
        else n_pass++;
        next_cyc();
        #1;
        n_chk++; if (dbg_ack !== 1'b1 || rf_rd_address !== 5'd0) $display("FAIL dbgw_ack: ack=%b addr=%0d want 1/0", dbg_ack, rf_rd_address); else n_pass++;
        dbg_req = 1'b0;
        next_cyc();
        #1;
        n_chk++; if (dbg_ack !== 1'b0 || mem[5] !== 32'h12345678) $display("FAIL dbgw_after: ack=%b x5=%h want 0/12345678", dbg_ack, mem[5]); else n_pass++;
    endtask

    task automatic test_dbg_read();
        next_cyc();
        wb_valid = 1'b1; wb_rd_address = 5'd7; wb_rd_data = 32'hA5A5A5A5;
        next_cyc();
        wb_valid = 1'b0;
        dec_rs1_address = 5'd2;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd7;
        #1;
        n_chk++; if (stall !== 1'b0 || rf_rs1_address !== 5'd2) $display("FAIL dbgr_req: stall=%b rs1=%0d want 0/2", stall, rf_rs1_address); else n_pass++;
        next_cyc();
        #1;
        n_chk++; if (stall !== 1'b1 || rf_rs1_address !== 5'd7 || dbg_ack !== 1'b0)
            $display("FAIL dbgr_steal: stall=%b rs1=%0d ack=%b want 1/7/0", stall, rf_rs1_address, dbg_ack);
        else n_pass++;
        next_cyc();
        #1;
        n_chk++; if (dbg_ack !== 1'b1 || dbg_rdata !== 32'hA5A5A5A5 || stall !== 1'b0)
            $display("FAIL dbgr_ack: ack=%b rdata=%h stall=%b want 1/a5a5a5a5/0", dbg_ack, dbg_rdata, stall);
        else n_pass++;
        dbg_req = 1'b0;
        next_cyc();
        #1;
        n_chk++; if (dbg_ack !== 1'b0 || dbg_rdata !== 32'hA5A5A5A5 || rf_rs1_address !== 5'd2)
            $display("FAIL dbgr_hold: ack=%b rdata=%h rs1=%0d want 0/a5a5a5a5/2", dbg_ack, dbg_rdata, rf_rs1_address);
        else n_pass++;
    endtask

    task automatic test_dbg_bypass();
        next_cyc();
        wb_valid = 1'b1; wb_rd_address = 5'd9; wb_rd_data = 32'h55555555;
        next_cyc();
        wb_valid = 1'b0;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd9;
        next_cyc();
        wb_valid = 1'b1; wb_rd_address = 5'd9; wb_rd_data = 32'h0BADF00D;
        #1;
        n_chk++; if (rf_rd_address !== 5'd9 || rf_rd_data !== 32'h0BADF00D || stall !== 1'b1)
            $display("FAIL byp_wb: addr=%0d data=%h stall=%b want 9/0badf00d/1", rf_rd_address, rf_rd_data, stall);
        else n_pass++;
        next_cyc();
        wb_valid = 1'b0;
        #1;
        n_chk++; if (dbg_ack !== 1'b1 || dbg_rdata !== 32'h0BADF00D)
            $display("FAIL byp_data: ack=%b rdata=%h want 1/0badf00d", dbg_ack, dbg_rdata);
        else n_pass++;
        dbg_req = 1'b0;
        next_cyc();
    endtask
`else
    task automatic test_dbg_disabled();
        next_cyc();
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd3;
        for (int i = 0; i < 10; i++) begin
            dec_rs1_address = 5'(i + 17);
            #1;
            n_chk++; if (dbg_ack !== 1'b0 || stall !== 1'b0 || dbg_rdata !== 32'h0)
                $display("FAIL dis_dbg[%0d]: ack=%b stall=%b rdata=%h want 0/0/0", i, dbg_ack, stall, dbg_rdata);
            else n_pass++;
            n_chk++; if (rf_rs1_address !== 5'(i + 17)) $display("FAIL dis_rs1[%0d]: got %0d want %0d", i, rf_rs1_address, i + 17); else n_pass++;
            next_cyc();
        end
        dbg_we = 1'b1; dbg_addr = 5'd6; dbg_wdata = 32'h77777777;
        #1;
        n_chk++; if (rf_rd_address !== 5'd0 || rf_rd_data !== 32'h0) $display("FAIL dis_wr: addr=%0d data=%h want 0/0", rf_rd_address, rf_rd_data); else n_pass++;
        next_cyc();
        dbg_req = 1'b0;
    endtask
`endif

    initial begin
        rst_n = 1'b0; wb_valid = 1'b0; wb_rd_address = '0; wb_rd_data = '0;
        dec_rs1_address = '0; dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
        test_reset();
        test_clear_walk();
        test_clear_restart();
        reset_and_clear();
        test_run_idle();
`ifdef REGFILE_DEBUG_PORT_EN
        test_dbg_write();
        test_dbg_read();
        test_dbg_bypass();
`else
        test_dbg_disabled();
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_regfile_port_ctrl
`default_nettype wire

// File: doc/regfile_port_ctrl.md
# regfile_port_ctrl

Sequencer and arbiter for the 32×32 integer register file's write port and first read port. After reset it walks every register to zero. It then grants the write port to pipeline writeback and admits a debug read/write requester in the gaps, stealing read port 1 for debug reads while stalling decode. It sits between decode/writeback and the register file, which writes unconditionally every clock; whenever no real write is pending, this block must drive a harmless x0←0 write.

## Interface
- NREGS, 32, number of architectural registers (power of two)
- XLEN, 32, register width
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- wb_valid  in  1  writeback has a result this cycle
- wb_rd_address  in  5  writeback destination
- wb_rd_data  in  XLEN  writeback data
- dec_rs1_address  in  5  decode's rs1 address
- rf_rs1_address  out  5  to register file read port 1
- rf_rs1_data  in  XLEN  from register file read port 1
- rf_rd_address  out  5  to register file write port
- rf_rd_data  out  XLEN  to register file write port
- stall  out  1  freeze decode and everything upstream
- init_done  out  1  clear sequence finished
- dbg_req  in  1  debug request, held until dbg_ack
- dbg_we  in  1  1 = write, 0 = read
- dbg_addr  in  5  debug register index
- dbg_wdata  in  XLEN  debug write data
- dbg_ack  out  1  one-cycle completion pulse
- dbg_rdata  out  XLEN  read result, valid with dbg_ack and held until the next ack

## Operation
- FSM states: CLEAR, RUN, DBG_READ, DBG_ACK.
- Reset (rst_n=0, any state): state←CLEAR, clear counter←0, dbg_ack=0, dbg_rdata=0, init_done=0. Reset mid-clear or mid-debug abandons the operation; the pending request gets no ack.
- CLEAR:
  - rf_rd_address=counter, rf_rd_data=0, stall=1.
  - Counter increments each cycle; after writing NREGS-1, go to RUN and set init_done=1.
  - wb_valid and dbg_req are ignored.
- Write port, RUN:
  - wb_valid=1: rf_rd_address/rf_rd_data = writeback values. Writeback always wins.
  - Otherwise, if dbg_req&dbg_we: write debug values, go to DBG_ACK.
  - Otherwise: rf_rd_address=0, rf_rd_data=0.
  - Any write to address 0 is forced to data 0.
- Debug write while wb_valid=1: waits in RUN, no ack, retried every cycle.
- Debug read, RUN with dbg_req&!dbg_we: go to DBG_READ. Writeback is not blocked.
- DBG_READ:
  - rf_rs1_address=dbg_addr, stall=1.
  - Capture dbg_rdata←rf_rs1_data, except when wb_valid and wb_rd_address==dbg_addr≠0; then capture wb_rd_data (bypass).
  - Address 0 reads 0.
  - Next state DBG_ACK.
- DBG_ACK: dbg_ack=1, next state RUN. The requester drops dbg_req in the ack cycle. The new request is sampled in the following RUN cycle.
- Outside DBG_READ, rf_rs1_address=dec_rs1_address. stall=1 only in CLEAR and DBG_READ.

## Timing
- Clear takes NREGS cycles: first rst_n=1 cycle is write #0, init_done rises on cycle NREGS.
- Debug write latency: write in the first eligible RUN cycle, dbg_ack in the next cycle.
- Debug read latency: req sampled in RUN cycle N, port stolen in N+1, dbg_ack with data in N+2.
- Maximum throughput is one debug op per 2 cycles (write) or 3 cycles (read).
- Decode stall for a read is exactly 1 cycle.
- dbg_ack, dbg_rdata and init_done are registered outputs. Port muxes are combinational from state.

## Configuration
- REGFILE_DEBUG_PORT_EN defined: full behaviour above.
- REGFILE_DEBUG_PORT_EN undefined:
  - DBG_READ/DBG_ACK are removed; dbg_* inputs are ignored; dbg_ack=0 and dbg_rdata=0 constantly.
  - stall is asserted only in CLEAR; rf_rs1_address=dec_rs1_address always.

## Structure
- Shared package holds the FSM state enum, the NREGS/XLEN defaults and the x0 index constant.
- No sub-module required; the clear counter and FSM live in one module.

## Test plan
- Reset, then release: rf_rd_address walks 0..31 with data 0 over 32 cycles, stall=1, init_done rises on cycle 32. Reasserting rst_n at cycle 10 restarts the walk at 0.
- RUN idle: rf_rd_address=0 and rf_rd_data=0 every cycle. wb_valid with address 0 and data 0xDEADBEEF drives data 0.
- Debug write x5←0x12345678 with wb_valid held high for 3 cycles: no write and no ack during those cycles. Write occurs on the 4th cycle, dbg_ack on the 5th.
- Debug read x7 (holding 0xA5A5A5A5): stall=1 for exactly one cycle, rf_rs1_address=7 in that cycle, dbg_ack with dbg_rdata=0xA5A5A5A5 two cycles after req.
- Debug read x9 while writeback writes x9←0x0BADF00D in the DBG_READ cycle: dbg_rdata=0x0BADF00D.
- Build without REGFILE_DEBUG_PORT_EN: a dbg_req read of x3 produces no ack and no stall over 10 cycles, and rf_rs1_address follows dec_rs1_address.
